// File: rtl/weight_bram_pkg.sv
// Shared constants and FSM encoding for the weight BRAM write loader and read-side counter.
package weight_bram_pkg;

   localparam int unsigned NUM_BRAMS_DEFAULT  = 16;
   localparam int unsigned ADDR_WIDTH_DEFAULT = 9;
   localparam int unsigned DATA_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Width of a BRAM index; never zero so a single-BRAM build still has a counter.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_bram_loader_if.sv
// Control, stream and BRAM write-port bundle for the weight loader.
interface weight_bram_loader_if
   import weight_bram_pkg::*;
#(
   parameter int unsigned NUM_BRAMS  = NUM_BRAMS_DEFAULT,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

   logic                             start;
   logic [ADDR_WIDTH-1:0]            addr_start;
   logic [ADDR_WIDTH-1:0]            addr_end;
   logic [DATA_WIDTH-1:0]            s_data;
   logic                             s_valid;
   logic                             s_ready;
   logic [NUM_BRAMS-1:0]             w_we;
   logic [NUM_BRAMS*ADDR_WIDTH-1:0]  w_addr_wr_flat;
   logic [DATA_WIDTH-1:0]            w_din;
   logic                             busy;
   logic                             done;

   // Requester / stream source side.
   modport master (
      output start, addr_start, addr_end, s_data, s_valid,
      input  s_ready, w_we, w_addr_wr_flat, w_din, busy, done
   );

   // Loader side.
   modport slave (
      input  start, addr_start, addr_end, s_data, s_valid,
      output s_ready, w_we, w_addr_wr_flat, w_din, busy, done
   );

endinterface

// File: rtl/onehot_decoder.sv
// Index to one-hot decoder with an enable gate; drives the per-BRAM write enables.
module onehot_decoder #(
   parameter int unsigned NUM_OUT = 16,
   parameter int unsigned IDX_W   = 4
) (
   input  logic [IDX_W-1:0]   idx_i,
   input  logic               en_i,
   output logic [NUM_OUT-1:0] onehot_c_o
);

   // One bit per output, high only for the selected index while enabled.
   always_comb begin
      onehot_c_o = '0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         onehot_c_o[i] = en_i && (idx_i == IDX_W'(i));
      end
   end

endmodule

// File: rtl/weight_bram_loader.sv
// Streams weight words into NUM_BRAMS BRAMs, address-major / BRAM-minor, one word per handshake.
module weight_bram_loader
   import weight_bram_pkg::*;
#(
   parameter int unsigned NUM_BRAMS  = NUM_BRAMS_DEFAULT,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input logic                 clk,
   input logic                 rst_n,
   weight_bram_loader_if.slave bus
);

   localparam int unsigned IDX_W = idx_width(NUM_BRAMS);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_WIDTH-1:0] end_addr_q, end_addr_d;
   logic [IDX_W-1:0]      bram_idx_q, bram_idx_d;
   logic                  s_ready_q, s_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [NUM_BRAMS-1:0]  w_we_q;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
   logic [DATA_WIDTH-1:0] w_din_q, w_din_d;
   logic [NUM_BRAMS-1:0]  we_onehot_c;
   logic                  xfer_c;
   logic                  idx_wrap_c;
   logic                  last_c;

   // Handshake qualifiers; s_ready is a flop, so no path from s_valid back to s_ready.
   assign xfer_c     = bus.s_valid && s_ready_q;
   assign idx_wrap_c = (bram_idx_q == IDX_W'(NUM_BRAMS - 1));
   assign last_c     = idx_wrap_c && (cur_addr_q == end_addr_q);

   // Write enable for the BRAM addressed by this cycle's transfer, registered below.
   onehot_decoder #(
      .NUM_OUT (NUM_BRAMS),
      .IDX_W   (IDX_W)
   ) u_we_dec (
      .idx_i      (bram_idx_q),
      .en_i       (xfer_c),
      .onehot_c_o (we_onehot_c)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      end_addr_d = end_addr_q;
      bram_idx_d = bram_idx_q;
      w_addr_d   = w_addr_q;
      w_din_d    = w_din_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               cur_addr_d = bus.addr_start;
               end_addr_d = bus.addr_end;
               bram_idx_d = '0;
               // An inverted range loads nothing but still completes through DRAIN.
               state_d    = (bus.addr_end < bus.addr_start) ? ST_DRAIN : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (xfer_c) begin
               w_addr_d = cur_addr_q;
               w_din_d  = bus.s_data;
               if (idx_wrap_c) begin
                  bram_idx_d = '0;
                  cur_addr_d = cur_addr_q + 1'b1;
               end else begin
                  bram_idx_d = bram_idx_q + 1'b1;
               end
               if (last_c) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      s_ready_d = (state_d == ST_LOAD);
      busy_d    = (state_d != ST_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= '0;
         end_addr_q <= '0;
         bram_idx_q <= '0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         w_we_q     <= '0;
         w_addr_q   <= '0;
         w_din_q    <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         end_addr_q <= end_addr_d;
         bram_idx_q <= bram_idx_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         w_we_q     <= we_onehot_c;
         w_addr_q   <= w_addr_d;
         w_din_q    <= w_din_d;
      end
   end

   // All BRAMs share the same write address; only the enabled one commits.
   assign bus.s_ready        = s_ready_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.w_we           = w_we_q;
   assign bus.w_din          = w_din_q;
   assign bus.w_addr_wr_flat = {NUM_BRAMS{w_addr_q}};

endmodule

// File: tb/tb_weight_bram_loader.sv
// Scoreboard bench for weight_bram_loader: expected writes queued at stimulus, popped by a monitor.
module tb_weight_bram_loader;
   import weight_bram_pkg::*;

   localparam int unsigned NB = NUM_BRAMS_DEFAULT;
   localparam int unsigned AW = ADDR_WIDTH_DEFAULT;
   localparam int unsigned DW = DATA_WIDTH_DEFAULT;

   typedef struct {
      int unsigned   bram;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   word_k;
   logic [DW-1:0] data_base;
   exp_t sb_q[$];
   exp_t mon_e;

   weight_bram_loader_if #(.NUM_BRAMS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   weight_bram_loader #(
      .NUM_BRAMS  (NB),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [NB*AW-1:0] rep_addr(input logic [AW-1:0] a);
      logic [NB*AW-1:0] r;
      for (int i = 0; i < int'(NB); i++) r[i*AW +: AW] = a;
      return r;
   endfunction

   // Queue writes for words first_k .. first_k+n-1 of a batch starting at addr_s.
   task automatic push_range(input logic [AW-1:0] addr_s, input logic [DW-1:0] base,
                             input int first_k, input int n);
      exp_t e;
      for (int k = first_k; k < first_k + n; k++) begin
         e.bram = k % NB;
         e.addr = AW'(addr_s + AW'(k / NB));
         e.data = DW'(base + DW'(k));
         sb_q.push_back(e);
      end
   endtask

   // Monitor: every asserted write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.w_we != '0) begin
         if (sb_q.size() == 0) begin
            check("unexpected_write", 256'(bus.w_we), 256'(0));
         end else begin
            mon_e = sb_q.pop_front();
            check("w_we", 256'(bus.w_we), 256'(NB'(1) << mon_e.bram));
            check("w_addr", 256'(bus.w_addr_wr_flat), 256'(rep_addr(mon_e.addr)));
            check("w_din", 256'(bus.w_din), 256'(mon_e.data));
         end
      end
   end

   // Pulse start in the current cycle; returns one cycle later, #1 after the edge.
   task automatic start_batch(input logic [AW-1:0] a_s, input logic [AW-1:0] a_e);
      bus.start      = 1'b1;
      bus.addr_start = a_s;
      bus.addr_end   = a_e;
      word_k         = 0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_start", 256'(bus.busy), 256'(1));
      check("s_ready_after_start", 256'(bus.s_ready), 256'(a_e >= a_s));
      check("done_after_start", 256'(bus.done), 256'(0));
   endtask

   // Offer n words; mode 1 toggles s_valid. inject_k >= 0 pulses a bogus start mid-load.
   task automatic feed(input int n, input int mode, input int inject_k);
      int  sent;
      int  cyc;
      logic rdy;
      logic v;
      sent = 0;
      cyc  = 0;
      while (sent < n) begin
         if (cyc > 4 * n + 20) begin
            check("feed_timeout", 256'(sent), 256'(n));
            break;
         end
         rdy         = bus.s_ready;
         v           = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         bus.s_valid = v;
         bus.s_data  = DW'(data_base + DW'(word_k));
         bus.start   = (inject_k >= 0) && (word_k == inject_k);
         if (bus.start) begin
            bus.addr_start = AW'(31);
            bus.addr_end   = AW'(40);
         end
         @(posedge clk); #1;
         if (v && rdy) begin
            sent++;
            word_k++;
         end
         cyc++;
      end
      bus.s_valid = 1'b0;
      bus.start   = 1'b0;
   endtask

   // Called just after the last transfer edge; returns #1 into the done cycle.
   task automatic finish_batch();
      check("s_ready_low_drain", 256'(bus.s_ready), 256'(0));
      check("busy_drain", 256'(bus.busy), 256'(1));
      check("done_drain", 256'(bus.done), 256'(0));
      @(posedge clk); #1;
      check("done_pulse", 256'(bus.done), 256'(1));
      check("busy_at_done", 256'(bus.busy), 256'(0));
      check("sb_empty_at_done", 256'(sb_q.size()), 256'(0));
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      word_k         = 0;
      data_base      = '0;
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.addr_start = '0;
      bus.addr_end   = '0;
      bus.s_data     = '0;
      bus.s_valid    = 1'b0;

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      check("rst_s_ready", 256'(bus.s_ready), 256'(0));
      check("rst_w_we", 256'(bus.w_we), 256'(0));
      check("rst_w_addr", 256'(bus.w_addr_wr_flat), 256'(0));
      check("rst_w_din", 256'(bus.w_din), 256'(0));
      check("rst_busy", 256'(bus.busy), 256'(0));
      check("rst_done", 256'(bus.done), 256'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single address row: w_we walks all 16 BRAMs at address 0.
      data_base = 16'hA000;
      push_range(AW'(0), data_base, 0, 16);
      start_batch(AW'(0), AW'(0));
      feed(16, 0, -1);
      finish_batch();
      @(posedge clk); #1;
      check("done_one_cycle_a", 256'(bus.done), 256'(0));

      // Rows 5..7, data 0..47, valid held high.
      data_base = 16'h0000;
      push_range(AW'(5), data_base, 0, 48);
      start_batch(AW'(5), AW'(7));
      feed(48, 0, -1);
      finish_batch();
      @(posedge clk); #1;
      check("done_one_cycle_b", 256'(bus.done), 256'(0));
      check("hold_w_din", 256'(bus.w_din), 256'(47));
      check("hold_w_addr", 256'(bus.w_addr_wr_flat), 256'(rep_addr(AW'(7))));

      // Same batch with toggling valid and an ignored start during LOAD.
      push_range(AW'(5), data_base, 0, 48);
      start_batch(AW'(5), AW'(7));
      feed(48, 1, 20);
      finish_batch();

      // Inverted range started in the done cycle: no writes, done two cycles later.
      start_batch(AW'(9), AW'(3));
      check("empty_s_ready", 256'(bus.s_ready), 256'(0));
      @(posedge clk); #1;
      check("empty_done", 256'(bus.done), 256'(1));
      check("empty_busy_at_done", 256'(bus.busy), 256'(0));

      // New batch accepted in that done cycle.
      data_base = 16'h5500;
      push_range(AW'(2), data_base, 0, 16);
      start_batch(AW'(2), AW'(2));
      feed(16, 0, -1);
      finish_batch();
      @(posedge clk); #1;

      // Reset after 10 transfers abandons the batch.
      data_base = 16'h7700;
      push_range(AW'(0), data_base, 0, 10);
      start_batch(AW'(0), AW'(3));
      feed(10, 0, -1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_s_ready", 256'(bus.s_ready), 256'(0));
      check("mid_rst_w_we", 256'(bus.w_we), 256'(0));
      check("mid_rst_w_addr", 256'(bus.w_addr_wr_flat), 256'(0));
      check("mid_rst_w_din", 256'(bus.w_din), 256'(0));
      check("mid_rst_busy", 256'(bus.busy), 256'(0));
      check("sb_empty_mid_rst", 256'(sb_q.size()), 256'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("mid_rst_no_done", 256'(bus.done), 256'(0));
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_no_done", 256'(bus.done), 256'(0));

      // Clean batch after reset starts at BRAM 0.
      data_base = 16'h3300;
      push_range(AW'(0), data_base, 0, 16);
      start_batch(AW'(0), AW'(0));
      feed(16, 0, -1);
      finish_batch();
      @(posedge clk); #1;
      check("final_idle_busy", 256'(bus.busy), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_bram_loader.md
WEIGHT_BRAM_LOADER -- requirements
Module: weight_bram_loader

Interface
REQ-001 SHALL have parameter NUM_BRAMS, default 16, number of weight BRAMs written.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, BRAM address width (512 entries).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, weight word width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load batch.
REQ-007 SHALL have port addr_start  input  ADDR_WIDTH  first BRAM address, sampled on accepted start.
REQ-008 SHALL have port addr_end  input  ADDR_WIDTH  last BRAM address inclusive, sampled on accepted start.
REQ-009 SHALL have port s_data  input  DATA_WIDTH  incoming weight word.
REQ-010 SHALL have port s_valid  input  1  s_data valid.
REQ-011 SHALL have port s_ready  output  1  loader accepts a word this cycle.
REQ-012 SHALL have port w_we  output  NUM_BRAMS  one-hot per-BRAM write enable.
REQ-013 SHALL have port w_addr_wr_flat  output  NUM_BRAMS*ADDR_WIDTH  per-BRAM write address, slice i = BRAM i.
REQ-014 SHALL have port w_din  output  DATA_WIDTH  write data broadcast to all BRAMs.
REQ-015 SHALL have port busy  output  1  high in LOAD and DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at batch completion.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, DRAIN; reset state IDLE.
REQ-018 SHALL accept start only in IDLE; start in LOAD/DRAIN ignored, no state change.
REQ-019 On accepted start: latch addr_start into cur_addr, addr_end into end_addr, bram_idx<=0, go LOAD.
REQ-020 SHALL drive s_ready = 1 exactly when state is LOAD (decoded from registered state, no combinational path from s_valid).
REQ-021 Handshake: a word transfers only in a cycle with s_valid && s_ready; s_valid low stalls without side effects.
REQ-022 Fill order: address-major, BRAM-minor; word k goes to BRAM (k mod NUM_BRAMS) at address addr_start + (k div NUM_BRAMS).
REQ-023 Write latency 1: transfer at cycle T -> at T+1 w_we bit bram_idx high, w_din = word, all w_addr_wr_flat slices = cur_addr of transfer.
REQ-024 w_we SHALL be zero in any cycle not following a transfer; w_din and w_addr_wr_flat hold last values when w_we is zero.
REQ-025 After each transfer bram_idx increments; at NUM_BRAMS-1 it wraps to 0 and cur_addr increments by 1 (ADDR_WIDTH modular).
REQ-026 Transfer with bram_idx = NUM_BRAMS-1 and cur_addr = end_addr is last: next state DRAIN, s_ready low from T+1.
REQ-027 DRAIN lasts one cycle (final write issued); then done=1 for one cycle and state IDLE, busy low the same cycle.
REQ-028 Total transfers per batch = (addr_end-addr_start+1)*NUM_BRAMS.
REQ-029 addr_end < addr_start at start: no words accepted, LOAD skipped, state DRAIN next, done pulses 2 cycles after start, w_we stays zero.
REQ-030 start accepted in the cycle done is high SHALL begin a new batch with fully reinitialised counters.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, s_ready=0, w_we=0, w_addr_wr_flat=0, w_din=0, busy=0, done=0, counters 0.
REQ-032 Reset mid-batch SHALL abandon the batch with no done pulse; next start begins cleanly.

Structure
REQ-033 Shared package weight_bram_pkg SHALL hold NUM_BRAMS, ADDR_WIDTH, DATA_WIDTH defaults and FSM state encoding, shared with the read-side counter.
REQ-034 Sub-module onehot_decoder (index -> NUM_BRAMS-bit one-hot, gated by enable) SHALL generate w_we.

Verification
REQ-035 start, addr_start=0, addr_end=0, s_valid held high -> 16 transfers, w_we walks 0x0001..0x8000 at addr 0, done 2 cycles after 16th transfer.
REQ-036 addr_start=5, addr_end=7, data 0..47 -> word 17 lands in BRAM 1 at addr 6; 48 writes; s_ready low after word 47.
REQ-037 s_valid toggled 1/0 every cycle -> w_we asserted only after valid cycles; write sequence identical to REQ-036.
REQ-038 start pulse during LOAD -> ignored; cur_addr, bram_idx, transfer count unchanged.
REQ-039 rst_n low after 10 transfers -> all outputs 0 next sample, no done; new start at addr 0 writes BRAM 0 first.
REQ-040 addr_start=9, addr_end=3 -> no s_ready, no w_we, done exactly 2 cycles after start.
